// File: rtl/pid_angle_ctrl.sv
// PID position controller for the swerve rotation motor: wrap-around angle error,
// P/I/D terms on a programmable sample period, PWM update/done handshake, settle, stall and abort.
module pid_angle_ctrl #(
    parameter int ANGLE_W       = 12,
    parameter int PWM_W         = 8,
    parameter int GAIN_W        = 8,
    parameter int GAIN_FRAC     = 4,
    parameter int I_LIMIT       = 1023,
    parameter int STALL_SAMPLES = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [ANGLE_W-1:0] target_angle,
    input  logic [ANGLE_W-1:0] current_angle,
    input  logic               angle_update,
    input  logic               abort_angle,
    input  logic               pwm_enable,
    input  logic               pwm_done,
    input  logic [15:0]        sample_period,
    input  logic [ANGLE_W-1:0] deadband,
    input  logic [7:0]         settle_count,
    input  logic               enable_stall_chk,
    input  logic [GAIN_W-1:0]  kp,
    input  logic [GAIN_W-1:0]  ki,
    input  logic [GAIN_W-1:0]  kd,
    output logic [PWM_W-1:0]   pwm_ratio,
    output logic               pwm_direction,
    output logic               pwm_update,
    output logic               angle_done,
    output logic               startup_fail,
    output logic               busy,
    output logic [15:0]        debug_signals
);
    localparam int W = ANGLE_W + GAIN_W + 12;
    localparam logic signed [W-1:0] ILIM = W'(I_LIMIT);
    localparam logic signed [W-1:0] RMAX = W'((1 << PWM_W) - 1);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_SAMPLE = 4'd1;
    localparam logic [3:0] S_CALC1  = 4'd2;
    localparam logic [3:0] S_CALC2  = 4'd3;
    localparam logic [3:0] S_APPLY  = 4'd4;
    localparam logic [3:0] S_WAIT   = 4'd5;
    localparam logic [3:0] S_DONE   = 4'd6;

    function automatic logic signed [W-1:0] gain_ext(input logic [GAIN_W-1:0] g);
        return $signed(W'(g));
    endfunction

    function automatic logic [ANGLE_W-1:0] abs_err(input logic signed [ANGLE_W-1:0] v);
        return v[ANGLE_W-1] ? ANGLE_W'(-v) : ANGLE_W'(v);
    endfunction

    // Returns {clamped, value}
    function automatic logic [W:0] clamp_i(input logic signed [W-1:0] v);
        if (v > ILIM)  return {1'b1, ILIM};
        if (v < -ILIM) return {1'b1, -ILIM};
        return {1'b0, v};
    endfunction

    // Returns {saturated, direction, ratio}
    function automatic logic [PWM_W+1:0] map_u(input logic signed [W-1:0] u);
        logic signed [W-1:0] mag;
        mag = u[W-1] ? -u : u;
        if (mag > RMAX) return {1'b1, ~u[W-1], {PWM_W{1'b1}}};
        return {1'b0, ~u[W-1], mag[PWM_W-1:0]};
    endfunction

    logic [3:0]                state_q, state_d;
    logic [ANGLE_W-1:0]        tgt_q, tgt_d;
    logic [15:0]               cnt_q, cnt_d;
    logic signed [ANGLE_W-1:0] e_q, e_d, eprev_q, eprev_d;
    logic signed [W-1:0]       integ_q, integ_d;
    logic [7:0]                settle_q, settle_d;
    logic [ANGLE_W-1:0]        min_q, min_d;
    logic [15:0]               stall_q, stall_d;
    logic                      fin_q, fin_d, upd_q, upd_d, dir_q, dir_d;
    logic                      fail_q, fail_d, sat_q, sat_d, iclamp_q, iclamp_d;
    logic [PWM_W-1:0]          ratio_q, ratio_d;

    logic signed [ANGLE_W-1:0] err_now;
    logic signed [W-1:0]       e_w, de_w, i_sum, i_next, u_p2;
    logic signed [W-1:0]       p_p1, i_p1, d_p1;
    logic                      i_clip, flip, m_sat, m_dir, in_band, improve, settled, stalled;
    logic [PWM_W-1:0]          m_ratio;
    logic [ANGLE_W-1:0]        e_abs;
    logic [15:0]               per_m1, stall_n;
    logic [7:0]                settle_inc, settle_tgt;

    assign err_now = $signed(tgt_q - current_angle);
    assign per_m1  = (sample_period == 16'd0) ? 16'd0 : sample_period - 16'd1;
    assign e_w     = W'(e_q);
    assign de_w    = e_w - W'(eprev_q);
    // Anti-windup: a zero crossing of the error discards the accumulated history
    assign flip    = (e_q != '0) && (eprev_q != '0) && (e_q[ANGLE_W-1] != eprev_q[ANGLE_W-1]);
    assign i_sum   = (flip ? '0 : integ_q) + e_w;
    assign {i_clip, i_next} = clamp_i(i_sum);

    // Stage p1: gain products
    always_ff @(posedge clock) begin
        if (state_q == S_CALC1) begin
            p_p1 <= gain_ext(kp) * e_w;
            i_p1 <= gain_ext(ki) * i_next;
            d_p1 <= gain_ext(kd) * de_w;
        end
    end

    // Stage p2: sum, scale, clamp to PWM range
    assign u_p2 = (p_p1 + i_p1 + d_p1) >>> GAIN_FRAC;
    assign {m_sat, m_dir, m_ratio} = map_u(u_p2);

    assign e_abs      = abs_err(e_q);
    assign in_band    = (e_abs <= deadband);
    assign settle_inc = in_band ? ((settle_q == 8'hFF) ? settle_q : settle_q + 8'd1) : 8'd0;
    assign settle_tgt = (settle_count == 8'd0) ? 8'd1 : settle_count;
    assign settled    = in_band && (settle_inc >= settle_tgt);
    assign improve    = (e_abs < min_q);
    assign stall_n    = improve ? 16'd0 : ((ratio_q != '0) ? stall_q + 16'd1 : stall_q);
    assign stalled    = enable_stall_chk && (stall_n >= 16'(STALL_SAMPLES));

    always_comb begin
        state_d = state_q;  tgt_d = tgt_q;  cnt_d = cnt_q;  e_d = e_q;  eprev_d = eprev_q;
        integ_d = integ_q;  settle_d = settle_q;  min_d = min_q;  stall_d = stall_q;
        fin_d = fin_q;  upd_d = 1'b0;  dir_d = dir_q;  ratio_d = ratio_q;
        fail_d = fail_q;  sat_d = sat_q;  iclamp_d = iclamp_q;
        if (!pwm_enable) begin
            state_d = S_IDLE;  ratio_d = '0;  dir_d = 1'b0;  fin_d = 1'b0;
        end else if (abort_angle && state_q != S_IDLE) begin
            state_d = S_IDLE;  upd_d = 1'b1;  ratio_d = '0;  dir_d = 1'b0;  fin_d = 1'b0;
        end else begin
            if (state_q != S_IDLE && cnt_q < per_m1) cnt_d = cnt_q + 16'd1;
            case (state_q)
                S_IDLE: if (angle_update) begin
                    tgt_d = target_angle;  integ_d = '0;  eprev_d = '0;  settle_d = '0;
                    fail_d = 1'b0;  cnt_d = '0;  min_d = '1;  stall_d = '0;  state_d = S_SAMPLE;
                end
                S_SAMPLE: if (cnt_q >= per_m1) begin
                    e_d = err_now;  cnt_d = '0;  state_d = S_CALC1;
                end
                S_CALC1: begin
                    integ_d = i_next;  iclamp_d = i_clip;  eprev_d = e_q;  state_d = S_CALC2;
                end
                S_CALC2: begin
                    settle_d = settle_inc;  stall_d = stall_n;  sat_d = m_sat;
                    min_d = improve ? e_abs : min_q;
                    upd_d = 1'b1;
                    if (settled) begin
                        ratio_d = '0;  dir_d = 1'b0;  fin_d = 1'b1;  state_d = S_APPLY;
                    end else if (stalled) begin
                        ratio_d = '0;  dir_d = 1'b0;  fail_d = 1'b1;  state_d = S_IDLE;
                    end else begin
                        ratio_d = m_ratio;  dir_d = m_dir;  state_d = S_APPLY;
                    end
                end
                S_APPLY: begin
                    state_d = fin_q ? S_DONE : S_WAIT;  fin_d = 1'b0;
                end
                S_WAIT:  if (pwm_done) state_d = S_SAMPLE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
            if (angle_update && state_q != S_IDLE) begin
                tgt_d = target_angle;  integ_d = '0;  settle_d = '0;  min_d = '1;  stall_d = '0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;  tgt_q <= '0;  cnt_q <= '0;  e_q <= '0;  eprev_q <= '0;
            integ_q <= '0;  settle_q <= '0;  min_q <= '1;  stall_q <= '0;  fin_q <= 1'b0;
            upd_q <= 1'b0;  dir_q <= 1'b0;  ratio_q <= '0;  fail_q <= 1'b0;
            sat_q <= 1'b0;  iclamp_q <= 1'b0;
        end else begin
            state_q <= state_d;  tgt_q <= tgt_d;  cnt_q <= cnt_d;  e_q <= e_d;  eprev_q <= eprev_d;
            integ_q <= integ_d;  settle_q <= settle_d;  min_q <= min_d;  stall_q <= stall_d;
            fin_q <= fin_d;  upd_q <= upd_d;  dir_q <= dir_d;  ratio_q <= ratio_d;
            fail_q <= fail_d;  sat_q <= sat_d;  iclamp_q <= iclamp_d;
        end
    end

    logic [7:0] dbg_ratio;
    assign dbg_ratio     = 8'(ratio_q);
    assign pwm_ratio     = ratio_q;
    assign pwm_direction = dir_q;
    assign pwm_update    = upd_q;
    assign angle_done    = (state_q == S_DONE);
    assign startup_fail  = fail_q;
    assign busy          = (state_q != S_IDLE);
    assign debug_signals = {state_q, e_q[ANGLE_W-1], sat_q, iclamp_q, 1'b0, dbg_ratio};

endmodule

// File: tb/tb_pid_angle_ctrl.sv
// Scoreboard bench for pid_angle_ctrl: expected PWM updates are queued by the stimulus
// and checked by an independent monitor whenever pwm_update is seen.
module tb_pid_angle_ctrl;
    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] target_angle, current_angle, deadband;
    logic        angle_update, abort_angle, pwm_enable, pwm_done, enable_stall_chk;
    logic [15:0] sample_period;
    logic [7:0]  settle_count, kp, ki, kd;
    logic [7:0]  pwm_ratio;
    logic        pwm_direction, pwm_update, angle_done, startup_fail, busy;
    logic [15:0] debug_signals;

    pid_angle_ctrl dut (
        .clock(clock), .reset(reset), .target_angle(target_angle), .current_angle(current_angle),
        .angle_update(angle_update), .abort_angle(abort_angle), .pwm_enable(pwm_enable),
        .pwm_done(pwm_done), .sample_period(sample_period), .deadband(deadband),
        .settle_count(settle_count), .enable_stall_chk(enable_stall_chk),
        .kp(kp), .ki(ki), .kd(kd), .pwm_ratio(pwm_ratio), .pwm_direction(pwm_direction),
        .pwm_update(pwm_update), .angle_done(angle_done), .startup_fail(startup_fail),
        .busy(busy), .debug_signals(debug_signals)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int upd_cnt = 0;
    int done_cnt = 0;
    logic [8:0] exp_q[$];   // {direction, ratio}

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", nm, act, req);
        end
    endtask

    // Monitor: pops one expected update per pwm_update pulse
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clock);
            if (reset === 1'b0 && pwm_update === 1'b1) begin
                upd_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL upd_unexpected#%0d got ratio=%0d dir=%0d expected no update",
                             upd_cnt, pwm_ratio, pwm_direction);
                end else begin
                    e = exp_q.pop_front();
                    if ({pwm_direction, pwm_ratio} !== e) begin
                        failures++;
                        $display("FAIL upd#%0d got ratio=%0d dir=%0d expected ratio=%0d dir=%0d",
                                 upd_cnt, pwm_ratio, pwm_direction, e[7:0], e[8]);
                    end
                end
            end
            if (reset === 1'b0 && angle_done === 1'b1) done_cnt++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic wait_upd(input int n);
        int k = 0;
        while (upd_cnt < n && k < 600) begin
            tick(1);
            k++;
        end
        chk("upd_wait", 32'(upd_cnt >= n), 32'd1);
    endtask

    task automatic push(input logic dir, input logic [7:0] r, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({dir, r});
    endtask

    task automatic start_run(input logic [11:0] tg, input logic [11:0] cur);
        target_angle = tg;
        current_angle = cur;
        angle_update = 1'b1;
        tick(1);
        angle_update = 1'b0;
    endtask

    task automatic do_abort();
        abort_angle = 1'b1;
        tick(1);
        abort_angle = 1'b0;
    endtask

    initial begin
        int base;
        int found;
        reset = 1'b1;  target_angle = '0;  current_angle = '0;  angle_update = 1'b0;
        abort_angle = 1'b0;  pwm_enable = 1'b1;  pwm_done = 1'b1;  sample_period = 16'd4;
        deadband = '0;  settle_count = 8'd0;  enable_stall_chk = 1'b0;
        kp = 8'h10;  ki = 8'h00;  kd = 8'h00;
        tick(3);
        chk("rst_ratio", 32'(pwm_ratio), 0);
        chk("rst_outputs", 32'({pwm_direction, pwm_update, angle_done, startup_fail, busy}), 0);
        chk("rst_debug", 32'(debug_signals), 0);
        reset = 1'b0;
        tick(2);

        // Wrap-around, P only: e = 100 - 4000 mod 4096 = 196
        base = upd_cnt;
        push(1'b1, 8'd196, 1);
        start_run(12'd100, 12'd4000);
        wait_upd(base + 1);
        chk("wrap_err_sign", 32'(debug_signals[11]), 0);
        chk("wrap_sat", 32'(debug_signals[10]), 0);
        push(1'b0, 8'd0, 1);
        do_abort();
        wait_upd(base + 2);
        chk("wrap_idle", 32'(busy), 0);

        // Negative error with output clamp: e = -300, u = -600
        kp = 8'h20;
        base = upd_cnt;
        push(1'b0, 8'd255, 1);
        start_run(12'd0, 12'd300);
        wait_upd(base + 1);
        chk("clamp_sat", 32'(debug_signals[10]), 1);
        chk("clamp_err_sign", 32'(debug_signals[11]), 1);
        push(1'b0, 8'd0, 1);
        do_abort();
        wait_upd(base + 2);

        // Integral windup: e = -50 each sample, I clamps at -1023 from sample 21
        kp = 8'h00;  ki = 8'h10;
        base = upd_cnt;
        for (int k = 1; k <= 5; k++) push(1'b0, 8'(50 * k), 1);
        push(1'b0, 8'd255, 25);
        start_run(12'd1000, 12'd1050);
        wait_upd(base + 30);
        chk("windup_iclamp", 32'(debug_signals[9]), 1);
        chk("windup_sat", 32'(debug_signals[10]), 1);
        current_angle = 12'd990;
        push(1'b1, 8'd10, 1);
        push(1'b1, 8'd20, 1);
        wait_upd(base + 32);
        chk("flip_iclamp", 32'(debug_signals[9]), 0);
        push(1'b0, 8'd0, 1);
        do_abort();
        wait_upd(base + 33);

        // Stall: error frozen at 500, 16 non-improving samples
        ki = 8'h00;  kp = 8'h10;  enable_stall_chk = 1'b1;
        base = upd_cnt;
        push(1'b1, 8'd255, 16);
        push(1'b0, 8'd0, 1);
        start_run(12'd500, 12'd0);
        wait_upd(base + 17);
        tick(2);
        chk("stall_flag", 32'(startup_fail), 1);
        chk("stall_idle", 32'(busy), 0);
        chk("stall_no_done", 32'(done_cnt), 0);
        enable_stall_chk = 1'b0;
        base = upd_cnt;
        push(1'b1, 8'd255, 1);
        start_run(12'd500, 12'd0);
        chk("stall_cleared", 32'(startup_fail), 0);
        wait_upd(base + 1);
        push(1'b0, 8'd0, 1);
        do_abort();
        wait_upd(base + 2);

        // Abort in WAIT_PWM with pwm_done low
        pwm_done = 1'b0;
        base = upd_cnt;
        push(1'b1, 8'd196, 1);
        start_run(12'd100, 12'd4000);
        wait_upd(base + 1);
        tick(5);
        chk("wait_state", 32'(debug_signals[15:12]), 5);
        push(1'b0, 8'd0, 1);
        do_abort();
        wait_upd(base + 2);
        chk("abort_idle", 32'(busy), 0);

        // Delayed pwm_done: no update until the generator answers
        base = upd_cnt;
        push(1'b1, 8'd196, 2);
        start_run(12'd100, 12'd4000);
        wait_upd(base + 1);
        tick(15);
        chk("no_extra_upd", 32'(upd_cnt - base), 1);
        pwm_done = 1'b1;
        tick(1);
        pwm_done = 1'b0;
        wait_upd(base + 2);
        push(1'b0, 8'd0, 1);
        do_abort();
        wait_upd(base + 3);

        // pwm_enable low: IDLE and zero ratio without handshake
        pwm_done = 1'b1;
        base = upd_cnt;
        push(1'b1, 8'd196, 1);
        start_run(12'd100, 12'd4000);
        wait_upd(base + 1);
        pwm_enable = 1'b0;
        tick(1);
        chk("disable_idle", 32'(busy), 0);
        chk("disable_ratio", 32'(pwm_ratio), 0);
        tick(20);
        chk("disable_no_upd", 32'(upd_cnt - base), 1);
        pwm_enable = 1'b1;
        tick(2);

        // Settle: e = 1 within deadband 2, done on the third settled sample
        deadband = 12'd2;  settle_count = 8'd3;
        base = upd_cnt;
        push(1'b1, 8'd1, 2);
        push(1'b0, 8'd0, 1);
        start_run(12'd500, 12'd499);
        wait_upd(base + 3);
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            @(negedge clock);
            if (angle_done === 1'b1) found = 1;
        end
        chk("settle_done_seen", 32'(found), 1);
        chk("settle_busy_at_done", 32'(busy), 1);
        @(negedge clock);
        chk("settle_busy_after", 32'(busy), 0);
        tick(3);
        chk("settle_done_count", 32'(done_cnt), 1);
        chk("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
